// File: rtl/regfile_preloader.sv
// Takes over the regfile write port to load registers FIRST_REG..LAST_REG from a valid/ready stream.
// Optional build macro PRELOAD_CHECKSUM_EN adds a wrapping sum of all accepted words.
module regfile_preloader #(
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 31,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  proc_we,
    input  logic [4:0]            proc_rd,
    input  logic [DATA_WIDTH-1:0] proc_data,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [5:0]            words_loaded
`ifdef PRELOAD_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [5:0] words_q, words_d;
    logic       accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        words_d  = words_q;
        accept   = 1'b0;
        rf_we    = proc_we;
        rf_rd    = proc_rd;
        rf_data  = proc_data;
        cpu_hold = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = FIRST_IDX;
                    words_d = '0;
                end
            end
            ST_LOAD: begin
                cpu_hold = 1'b1;
                in_ready = 1'b1;
                rf_rd    = idx_q;
                rf_data  = in_data;
                // abort wins over a word offered in the same cycle; r0 words are consumed but never written
                accept   = in_valid && !abort;
                rf_we    = accept && (idx_q != 5'd0);
                if (abort) begin
                    state_d = ST_DONE;
                end else if (accept) begin
                    words_d = words_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                cpu_hold = 1'b1;
                done     = 1'b1;
                rf_we    = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign words_loaded = words_q;

`ifdef PRELOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE && start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule
